// File: rtl/link_tx_sender.sv
// TX-side link sender: valid/ready flits out onto a strobe/state framed link with an inter-flit gap.
// Optional statistics counters are built when LINK_TX_STATS_EN is defined.
`ifndef CDATASIZE
`define CDATASIZE 8
`endif

module link_tx_sender #(
  parameter int unsigned CDATASIZE = `CDATASIZE,
  parameter int unsigned GAP_W     = 4
`ifdef LINK_TX_STATS_EN
  , parameter int unsigned STAT_W  = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GAP_W-1:0]     gap,
  input  logic [CDATASIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 Feedback_p2r,
  output logic [CDATASIZE-1:0] CData_r2p,
  output logic                 Strobe_r2p,
  output logic                 State_r2p,
  output logic                 Clock_r2p
`ifdef LINK_TX_STATS_EN
  , output logic [STAT_W-1:0]  flit_cnt
  , output logic [STAT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    READY = 2'd0,
    GAP   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [CDATASIZE-1:0]   data_q, data_d;
  logic                   strobe_q, strobe_d;
  logic                   frame_q, frame_d;
  logic                   tail_pend_q, tail_pend_d;
  logic                   fb_meta_q, alert_s_q;
  logic                   accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_meta_q <= 1'b0;
      alert_s_q <= 1'b0;
    end else begin
      fb_meta_q <= Feedback_p2r;
      alert_s_q <= fb_meta_q;
    end
  end

  assign in_ready = (state_q == READY) && !alert_s_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    strobe_d    = strobe_q;
    frame_d     = frame_q;
    tail_pend_d = tail_pend_q;

    case (state_q)
      READY: begin
        if (accept) begin
          if (gap != '0) state_d = GAP;
        end else if (alert_s_q) begin
          state_d = STALL;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) state_d = alert_s_q ? STALL : READY;
      end
      STALL: begin
        if (!alert_s_q) state_d = READY;
      end
      default: state_d = READY;
    endcase

    // A head accepted on the frame-clearing edge keeps the frame up and reloads the tail flag.
    if (accept) begin
      data_d      = in_data;
      strobe_d    = ~strobe_q;
      frame_d     = 1'b1;
      gap_cnt_d   = gap;
      tail_pend_d = in_data[CDATASIZE-1];
    end else if (state_q != GAP && tail_pend_q) begin
      frame_d     = 1'b0;
      tail_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= READY;
      gap_cnt_q   <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      frame_q     <= 1'b0;
      tail_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      frame_q     <= frame_d;
      tail_pend_q <= tail_pend_d;
    end
  end

  assign CData_r2p  = data_q;
  assign Strobe_r2p = strobe_q;
  assign State_r2p  = frame_q;
  assign Clock_r2p  = clk;

`ifdef LINK_TX_STATS_EN
  logic [STAT_W-1:0] flit_cnt_q, flit_cnt_d;
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flit_cnt_d  = flit_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && flit_cnt_q != '1) flit_cnt_d = flit_cnt_q + STAT_W'(1);
    if (state_q == STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      flit_cnt_q  <= flit_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flit_cnt  = flit_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_link_tx_sender.sv
// Scoreboard bench for link_tx_sender: accepted flits are queued, a negedge monitor checks each strobe toggle.
module tb_link_tx_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gap = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       Feedback_p2r = 1'b0;
  logic [7:0] CData_r2p;
  logic       Strobe_r2p, State_r2p, Clock_r2p;
`ifdef LINK_TX_STATS_EN
  logic [15:0] flit_cnt, stall_cnt;
`endif

  link_tx_sender #(.CDATASIZE(8), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .gap(gap), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .Feedback_p2r(Feedback_p2r), .CData_r2p(CData_r2p),
    .Strobe_r2p(Strobe_r2p), .State_r2p(State_r2p), .Clock_r2p(Clock_r2p)
`ifdef LINK_TX_STATS_EN
    , .flit_cnt(flit_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int unsigned tog_q[$];
  int unsigned falls = 0;
  int unsigned last_fall = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe toggle must carry the oldest outstanding accepted flit.
  initial begin : monitor
    logic prev_s, prev_f;
    logic [7:0] e;
    prev_s = 1'b0;
    prev_f = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (Strobe_r2p !== prev_s) begin
          tog_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("spurious_toggle", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("cdata", int'(CData_r2p), int'(e));
          end
        end
        if (prev_f && !State_r2p) begin
          falls++;
          last_fall = cyc;
        end
      end
      prev_s = Strobe_r2p;
      prev_f = State_r2p;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offer one flit; returns the edge number on which it was accepted.
  task automatic send(input logic [7:0] d, input logic [3:0] g, output int unsigned acc);
    int n;
    n = 0;
    in_data  = d;
    gap      = g;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
    end else begin
      exp_q.push_back(d);
    end
    tick();
    acc = cyc;
    in_valid = 1'b0;
  endtask

  initial begin : stim
    int unsigned h, t0, f0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cdata", int'(CData_r2p), 0);
    chk("rst_strobe", int'(Strobe_r2p), 0);
    chk("rst_state", int'(State_r2p), 0);
    chk("rst_ready", int'(in_ready), 1);
`ifdef LINK_TX_STATS_EN
    chk("rst_flit_cnt", int'(flit_cnt), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
`endif

    // gap=0 back-to-back 4-flit packet
    tog_q.delete();
    f0 = falls;
    send(8'h01, 4'd0, h);
    send(8'h02, 4'd0, t0);
    send(8'h03, 4'd0, t0);
    send(8'h84, 4'd0, t0);
    tick();
    tick();
    chk("b2b_toggles", tog_q.size(), 4);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", tog_q[i] - tog_q[0], i);
    chk("b2b_falls", falls - f0, 1);
    chk("b2b_state_span", last_fall - h + 1, 5);
    chk("b2b_state_low", int'(State_r2p), 0);

    // gap=3 single-flit packets
    f0 = falls;
    send(8'h91, 4'd3, h);
    chk("gap_ready_low0", int'(in_ready), 0);
    tick();
    chk("gap_ready_low1", int'(in_ready), 0);
    tick();
    chk("gap_ready_low2", int'(in_ready), 0);
    tick();
    chk("gap_ready_back", int'(in_ready), 1);
    tick();
    chk("gap_fall1", falls - f0, 1);
    chk("gap_span1", last_fall - h + 1, 5);
    send(8'hA2, 4'd3, h);
    repeat (5) tick();
    chk("gap_fall2", falls - f0, 2);
    chk("gap_span2", last_fall - h + 1, 5);

    // receiver alert in mid-packet
    f0 = falls;
    send(8'h11, 4'd0, h);
    t0 = tog_q.size();
    Feedback_p2r = 1'b1;
    tick();
    chk("alert_ready_pre", int'(in_ready), 1);
    tick();
    chk("alert_ready_low", int'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alert_state_hold", int'(State_r2p), 1);
    end
    Feedback_p2r = 1'b0;
    tick();
    tick();
    chk("alert_ready_still_low", int'(in_ready), 0);
    tick();
    chk("alert_ready_resume", int'(in_ready), 1);
    chk("alert_no_toggle", tog_q.size(), t0);
    chk("alert_no_fall", falls - f0, 0);
`ifdef LINK_TX_STATS_EN
    chk("stall_cnt", int'(stall_cnt), 6);
    chk("flit_cnt", int'(flit_cnt), 7);
`endif
    send(8'h85, 4'd0, t0);
    tick();
    chk("alert_tail_fall", falls - f0, 1);
    chk("alert_tail_state", int'(State_r2p), 0);

    // head offered on the frame-clearing edge
    tog_q.delete();
    f0 = falls;
    send(8'hC1, 4'd3, h);
    send(8'h12, 4'd0, t0);
    send(8'h93, 4'd0, t0);
    tick();
    tick();
    chk("join_toggles", tog_q.size(), 3);
    chk("join_gap_spacing", tog_q[1] - tog_q[0], 4);
    chk("join_b2b_spacing", tog_q[2] - tog_q[1], 1);
    chk("join_falls", falls - f0, 1);
    chk("join_span", last_fall - h + 1, 7);

    // asynchronous reset during GAP
    send(8'hA5, 4'd5, h);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_cdata", int'(CData_r2p), 0);
    chk("arst_strobe", int'(Strobe_r2p), 0);
    chk("arst_state", int'(State_r2p), 0);
    chk("arst_ready", int'(in_ready), 1);
`ifdef LINK_TX_STATS_EN
    chk("arst_flit_cnt", int'(flit_cnt), 0);
    chk("arst_stall_cnt", int'(stall_cnt), 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    f0 = falls;
    send(8'h86, 4'd0, h);
    tick();
    tick();
    chk("post_rst_strobe", int'(Strobe_r2p), 1);
    chk("post_rst_fall", falls - f0, 1);
    chk("post_rst_span", last_fall - h + 1, 2);
`ifdef LINK_TX_STATS_EN
    chk("post_rst_flit_cnt", int'(flit_cnt), 1);
`endif
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
